sipo_loader: RTL

Serial-in/parallel-out loader that assembles a framed serial bit stream into a WIDTH-bit word. It sits directly upstream of the enabled D flip-flop register bank. Its `q` bus drives the bank's `d` inputs, and its one-cycle `we` strobe drives the bank's `e` enable, so the bank captures each completed word exactly once. Partial frames never reach the outputs.

---
 rtl/sipo_loader.sv | 112 +++++++++++
 1 files changed

// File: rtl/sipo_loader.sv
// sipo_loader: serial-in/parallel-out loader.
// Assembles a start-framed serial bit stream into a WIDTH-bit word. It drives
// a downstream enabled register bank: q feeds the bank's d inputs, and the
// one-cycle we pulse feeds its enable. Partial frames never reach q.
//
// Ports:
//   clk      in   rising-edge clock
//   clr      in   synchronous active-high clear; overrides every other input
//   start    in   frame start strobe; restarts the frame if one is in progress
//   sin      in   serial data bit
//   sin_en   in   sin is valid this cycle (ignored while idle)
//   q        out  last completed word (registered)
//   we       out  one-cycle pulse marking a new q
//   busy     out  high while a frame is being collected
//   bit_cnt  out  bits collected so far in the current frame
module sipo_loader #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     start,
  input  logic                     sin,
  input  logic                     sin_en,
  output logic [WIDTH-1:0]         q,
  output logic                     we,
  output logic                     busy,
  output logic [$clog2(WIDTH):0]   bit_cnt
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] sr_reg, sr_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic             we_reg, we_next;
  logic [WIDTH-1:0] sr_shift;

  // Shift direction is fixed at elaboration time.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign sr_shift = {sr_reg[WIDTH-2:0], sin};
    end else begin : g_lsb_first
      assign sr_shift = {sin, sr_reg[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (clr) begin
      state_reg <= IDLE;
      sr_reg    <= '0;
      cnt_reg   <= '0;
      q_reg     <= '0;
      we_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      sr_reg    <= sr_next;
      cnt_reg   <= cnt_next;
      q_reg     <= q_next;
      we_reg    <= we_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    sr_next    = sr_reg;
    cnt_next   = cnt_reg;
    q_next     = q_reg;
    we_next    = 1'b0;

    case (state_reg)
      IDLE: begin
        // A bit that arrives together with start is deliberately dropped.
        if (start) begin
          state_next = SHIFT;
          sr_next    = '0;
          cnt_next   = '0;
        end
      end
      SHIFT: begin
        if (start) begin
          // Restart wins even over the would-be final bit: no word is issued.
          sr_next  = '0;
          cnt_next = '0;
        end else if (sin_en) begin
          sr_next = sr_shift;
          if (cnt_reg == CW'(WIDTH - 1)) begin
            // Final bit: publish the word including the current sin.
            q_next     = sr_shift;
            we_next    = 1'b1;
            cnt_next   = '0;
            state_next = IDLE;
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign q       = q_reg;
  assign we      = we_reg;
  assign busy    = (state_reg == SHIFT);
  assign bit_cnt = cnt_reg;

endmodule
